fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_if.sv | 49 ++++
 rtl/fetch_unit.sv | 80 ++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: EX-stage redirect/training inputs, instruction-memory port and fetch outputs.
// The master modport is the fetch unit; the slave modport is the pipeline/memory side.
interface fetch_if;
  logic        stall_F;
  logic        redirect_EX;
  logic [31:0] redirect_pc_EX;
  logic        BP_update_en_EX;
  logic        BP_taken_EX;
  logic [31:0] PC_update_EX;
  logic [31:0] imem_data_F;
  logic [31:0] imem_addr_F;
  logic [31:0] PC_out_F;
  logic [31:0] normal_F;
  logic [31:0] InstructionMemory_out_F;
  logic        BP_en_F;
  logic        BP_decision_F;

  modport master (
    input  stall_F,
    input  redirect_EX,
    input  redirect_pc_EX,
    input  BP_update_en_EX,
    input  BP_taken_EX,
    input  PC_update_EX,
    input  imem_data_F,
    output imem_addr_F,
    output PC_out_F,
    output normal_F,
    output InstructionMemory_out_F,
    output BP_en_F,
    output BP_decision_F
  );

  modport slave (
    output stall_F,
    output redirect_EX,
    output redirect_pc_EX,
    output BP_update_en_EX,
    output BP_taken_EX,
    output PC_update_EX,
    output imem_data_F,
    input  imem_addr_F,
    input  PC_out_F,
    input  normal_F,
    input  InstructionMemory_out_F,
    input  BP_en_F,
    input  BP_decision_F
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC selection and a 16-entry bimodal (2-bit counter) predictor
// for conditional branches.
module fetch_unit (
  input  logic   clk,
  input  logic   rst,
  fetch_if.master bus
);
  localparam logic [6:0]  BranchOpcode = 7'b1100011;
  localparam logic [1:0]  CntReset     = 2'b01;
  localparam logic [31:0] PcStep       = 32'd4;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  bht_q [16];
  logic [1:0]  bht_d [16];

  logic [3:0]  fetch_idx;
  logic [3:0]  upd_idx;
  logic        is_branch;
  logic        decision;
  logic [31:0] b_imm;
  logic [31:0] target;
  logic [31:0] normal;

  always_comb begin
    fetch_idx = pc_q[5:2];
    is_branch = (bus.imem_data_F[6:0] == BranchOpcode);
    // Prediction reads the registered counter, so a same-cycle update is seen one cycle later.
    decision  = is_branch & bht_q[fetch_idx][1];
    b_imm     = {{19{bus.imem_data_F[31]}}, bus.imem_data_F[31], bus.imem_data_F[7],
                 bus.imem_data_F[30:25], bus.imem_data_F[11:8], 1'b0};
    target    = pc_q + b_imm;
    normal    = pc_q + PcStep;
  end

  always_comb begin
    pc_d = normal;
    if (bus.redirect_EX) begin
      pc_d = bus.redirect_pc_EX;
    end else if (bus.stall_F) begin
      pc_d = pc_q;
    end else if (decision) begin
      pc_d = target;
    end
  end

  always_comb begin
    upd_idx = bus.PC_update_EX[5:2];
    for (int i = 0; i < 16; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (bus.BP_update_en_EX) begin
      if (bus.BP_taken_EX) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= 32'h0;
      for (int i = 0; i < 16; i++) begin
        bht_q[i] <= CntReset;
      end
    end else begin
      pc_q <= pc_d;
      for (int i = 0; i < 16; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  assign bus.PC_out_F                = pc_q;
  assign bus.imem_addr_F             = pc_q;
  assign bus.normal_F                = normal;
  assign bus.InstructionMemory_out_F = bus.imem_data_F;
  assign bus.BP_en_F                 = is_branch;
  assign bus.BP_decision_F           = decision;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, async-reset sequence and a
// randomized run against a behavioural model of PC selection and predictor training.
module tb_fetch_unit;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if fif ();
  fetch_unit dut (.clk(clk), .rst(rst), .bus(fif));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        upd;
    logic        tk;
    logic [31:0] upc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        en;
    logic        dec;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] br(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic u, input logic t, input logic [31:0] up,
                              input logic [31:0] ins, input logic [31:0] p,
                              input logic e, input logic d);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp; v.upd = u; v.tk = t; v.upc = up;
    v.instr = ins; v.pc = p; v.en = e; v.dec = d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic u,
                       input logic t, input logic [31:0] up, input logic [31:0] ins);
    fif.stall_F = s; fif.redirect_EX = r; fif.redirect_pc_EX = rp;
    fif.BP_update_en_EX = u; fif.BP_taken_EX = t; fif.PC_update_EX = up;
    fif.imem_data_F = ins;
  endtask

  task automatic chk_outputs(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic en, input logic dec);
    chk({tag, ".pc"}, fif.PC_out_F, pc);
    chk({tag, ".addr"}, fif.imem_addr_F, pc);
    chk({tag, ".normal"}, fif.normal_F, pc + 32'd4);
    chk({tag, ".imem_out"}, fif.InstructionMemory_out_F, ins);
    chk({tag, ".bp_en"}, {31'd0, fif.BP_en_F}, {31'd0, en});
    chk({tag, ".bp_dec"}, {31'd0, fif.BP_decision_F}, {31'd0, dec});
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Nop);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Behavioural reference state for the random run
  logic [31:0] m_pc;
  int          m_cnt [16];

  initial begin
    string tag;
    logic [31:0] ins, rp, up, tgt, nxt;
    logic        s, r, u, t, isb, dec;
    logic [12:0] imm;
    int          ui;

    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Nop);
    #2;
    chk("reset.pc", fif.PC_out_F, 32'h0);
    chk("reset.normal", fif.normal_F, 32'h4);
    chk("reset.dec", {31'd0, fif.BP_decision_F}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    //          stall redir rpc          upd tk upc          instr          pc           en dec
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  Nop,           32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  Nop,           32'h4,        0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,  Nop,           32'h8,        0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,  Nop,           32'h8,        0, 0));
    vecs.push_back(mk(1, 1, 32'h100,      0, 0, 32'h0,  Nop,           32'h8,        0, 0));
    vecs.push_back(mk(0, 1, 32'h10,       0, 0, 32'h0,  Nop,           32'h100,      0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  br(13'h10),    32'h10,       1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h10, Nop,           32'h14,       0, 0));
    vecs.push_back(mk(0, 1, 32'h10,       0, 0, 32'h0,  Nop,           32'h18,       0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  br(13'h10),    32'h10,       1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h10, Nop,           32'h20,       0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h10, Nop,           32'h24,       0, 0));
    vecs.push_back(mk(0, 1, 32'h10,       1, 0, 32'h10, Nop,           32'h28,       0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h10, br(13'h10),    32'h10,       1, 0));
    vecs.push_back(mk(0, 1, 32'h10,       1, 1, 32'h10, Nop,           32'h14,       0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  br(13'h10),    32'h10,       1, 1));
    vecs.push_back(mk(0, 1, 32'h40,       1, 1, 32'h40, Nop,           32'h20,       0, 0));
    vecs.push_back(mk(0, 1, 32'h200,      0, 0, 32'h0,  br(13'h10),    32'h40,       1, 1));
    vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,  Nop,           32'h200,      0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  Nop,           32'hFFFFFFFC, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  br(13'h1FF8),  32'h0,        1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  Nop,           32'hFFFFFFF8, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].upd, vecs[i].tk, vecs[i].upc,
            vecs[i].instr);
      @(negedge clk);
      tag = $sformatf("vec%0d", i);
      chk_outputs(tag, vecs[i].pc, vecs[i].instr, vecs[i].en, vecs[i].dec);
      @(posedge clk);
      #1;
    end

    // Train entry 15 to strongly-taken at PC 0x3C, then reset mid-cycle
    drive(0, 1, 32'h3C, 1, 1, 32'h3C, Nop);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 1, 1, 32'h3C, Nop);
    @(negedge clk);
    chk("seq.pc_3c", fif.PC_out_F, 32'h3C);
    @(posedge clk); #1;
    drive(1, 0, 32'h0, 0, 0, 32'h0, br(13'h10));
    @(negedge clk);
    chk("seq.trained_dec", {31'd0, fif.BP_decision_F}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("seq.async_pc", fif.PC_out_F, 32'h0);
    chk("seq.async_normal", fif.normal_F, 32'h4);
    chk("seq.async_dec", {31'd0, fif.BP_decision_F}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, 32'(4 * (k + 1)), 0, 0, 32'h0, br(13'h10));
      @(negedge clk);
      tag = $sformatf("postrst%0d", k);
      chk_outputs(tag, 32'(4 * k), br(13'h10), 1'b1, 1'b0);
      @(posedge clk); #1;
    end

    // Randomized run against the behavioural model
    do_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 1;
    for (int n = 0; n < 3000; n++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      rp = {$urandom_range(0, 255), 2'b00};
      u = ($urandom_range(0, 2) == 0);
      t = $urandom_range(0, 1);
      up = {$urandom_range(0, 63), 2'b00};
      if ($urandom_range(0, 1) == 1) begin
        imm = 13'($urandom) & 13'h1FFE;
        ins = br(imm);
      end else begin
        ins = $urandom;
      end
      drive(s, r, rp, u, t, up, ins);

      isb = (ins[6:0] == 7'b1100011);
      dec = isb && (m_cnt[m_pc[5:2]] >= 2);
      tgt = m_pc + 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      @(negedge clk);
      tag = $sformatf("rnd%0d", n);
      chk_outputs(tag, m_pc, ins, isb, dec);

      if (r)        nxt = rp;
      else if (s)   nxt = m_pc;
      else if (dec) nxt = tgt;
      else          nxt = m_pc + 32'd4;
      m_pc = nxt;
      if (u) begin
        ui = int'(up[5:2]);
        if (t) m_cnt[ui] = (m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1;
        else   m_cnt[ui] = (m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1;
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
